// File: rtl/seg_walker_fsm.sv
// Multi-channel segmented walker FSM: climb chain, fall/trap region, optional
// timed trap escape and a saturating lap counter per channel, plus a legality invariant.
module seg_walker_fsm #(
  parameter int NCH       = 2,
  parameter int DEPTH     = 2,
  parameter int SW        = 8,
  parameter int TRAP_WAIT = 3,
  parameter int ESCAPE    = 0,
  parameter int CW        = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [NCH-1:0]    i,
  input  logic [NCH-1:0]    en,
  input  logic [NCH-1:0]    clr,
  output logic [NCH*SW-1:0] state,
  output logic [NCH-1:0]    o,
  output logic [NCH-1:0]    trapped,
  output logic [NCH*CW-1:0] laps,
  output logic              prop
);

  localparam int DW = $clog2(TRAP_WAIT + 1);

  typedef enum logic [SW-1:0] {
    IDLE   = SW'(0),
    STEP_1 = SW'(1),
    LAST   = SW'(DEPTH),
    FALL   = SW'(DEPTH + 1),
    TRAP   = SW'(DEPTH + 2)
  } walk_t;

  logic [SW-1:0] st [NCH];
  logic [DW-1:0] dw [NCH];
  logic [CW-1:0] lp [NCH];

  for (genvar c = 0; c < NCH; c++) begin : g_ch
    always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
        st[c] <= '0;
        dw[c] <= '0;
        lp[c] <= '0;
      end else if (clr[c]) begin
        st[c] <= IDLE;
        dw[c] <= '0;
      end else if (en[c]) begin
        case (st[c])
          IDLE: begin
            st[c] <= i[c] ? STEP_1 : IDLE;
            dw[c] <= '0;
          end
          LAST: begin
            st[c] <= STEP_1;
            dw[c] <= '0;
            if (lp[c] != '1)
              lp[c] <= lp[c] + CW'(1);
          end
          FALL: begin
            st[c] <= TRAP;
            dw[c] <= '0;
          end
          TRAP: begin
            if (ESCAPE != 0) begin
              if (dw[c] == DW'(TRAP_WAIT - 1)) begin
                st[c] <= IDLE;
                dw[c] <= '0;
              end else begin
                dw[c] <= dw[c] + DW'(1);
              end
            end
          end
          default: begin
            // Remaining codes are either intermediate climb steps or unreachable encodings.
            if (st[c] < LAST)
              st[c] <= i[c] ? st[c] + SW'(1) : FALL;
            else
              st[c] <= IDLE;
            dw[c] <= '0;
          end
        endcase
      end
    end

    assign state[c*SW +: SW] = st[c];
    assign laps[c*CW +: CW]  = lp[c];
    assign o[c]              = (st[c] == IDLE);
    assign trapped[c]        = (st[c] == TRAP);
  end

  always_comb begin
    prop = 1'b1;
    for (int unsigned c = 0; c < NCH; c++)
      prop = prop & (st[c] <= TRAP) & (dw[c] <= DW'(TRAP_WAIT - 1));
  end

  a_prop: assert property (@(posedge clock) disable iff (reset) prop);

endmodule
